relogio: RTL and testbench
==========================

Name: relogio

Overview:
- 24-hour wall clock (HH:MM:SS) with time-setting mode, driving an 8-digit multiplexed seven-segment display.
- Top-level block of the board design. Pushbutton-level inputs are soma (increment), subtracao (decrement) and cont (mode advance).
- Outputs are active-low digit anodes and active-low cathodes.

Parameters:
- TICK_DIV, 100000000, clock cycles per one-second tick (≥2).
- SCAN_DIV, 100000, clock cycles each display digit stays selected (≥1).

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- soma  input  1  asynchronous button level; each rising edge adds 1 to the selected field.
- subtracao  input  1  asynchronous button level; each rising edge subtracts 1 from the selected field.
- cont  input  1  asynchronous button level; each rising edge advances the mode.
- an  output  8  digit enables, active-low one-hot; bit 0 = rightmost digit.
- dec_cat  output  8  segments, active-low, bit7..0 = a,b,c,d,e,f,g,dp.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Input conditioning:
  - Each of soma, subtracao, cont passes through a 2-flop synchronizer (reset to 0), then a rising-edge detector.
  - A level held high for many cycles yields exactly one event.
  - An input high at edges k, k+1, k+2 acts on edge k+2.
- Prescaler: free-running counter 0..TICK_DIV-1. tick = 1 for one cycle when the counter is at TICK_DIV-1.
- Mode FSM, states RUN, SET_H, SET_M, SET_S. A cont event advances RUN→SET_H→SET_M→SET_S→RUN.
- Time registers:
  - hours 0..23, minutes 0..59, seconds 0..59, stored as BCD tens/units.
  - Reset: 00:00:00, mode RUN, prescaler 0, scan index 0.
- RUN mode:
  - On tick, seconds+1. 59 wraps to 0 with a minute carry; minute 59 wraps with an hour carry; hour 23 wraps to 0.
  - 23:59:59 + tick = 00:00:00.
  - soma/subtracao ignored.
- SET modes:
  - Time does not advance; ticks ignored.
  - soma event: selected field +1 (hours 23→0, min/sec 59→0), no carry to other fields.
  - subtracao event: selected field −1 (hours 0→23, min/sec 0→59), no borrow.
- Simultaneous events:
  - soma and subtracao in the same cycle: no change.
  - cont in the same cycle as soma/subtracao: mode advances, field not adjusted.
- Reset mid-operation: everything returns to reset values on the next edge; pending edges are discarded.
- Display:
  - Scan counter 0..SCAN_DIV-1; on wrap, digit index 0..7 increments, 7→0.
  - Digit map, index 7..0: H tens, H units, dash, M tens, M units, dash, S tens, S units.
  - an = ~(1<<index), combinational from the index register.
  - dec_cat is the code of the selected digit.
  - After reset: an=8'hFE, dec_cat=8'h03.
- Segment codes: 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09, dash=FD, blank=FF. dp always off.

Optional Feature:
- Macro RELOGIO_BLINK_EN.
- Defined:
  - In SET_H/SET_M/SET_S, the two digits of the selected field show blank (FF) while the prescaler is ≥ TICK_DIV/2.
  - an still asserts normally; other digits are unchanged.
- Undefined: no blanking; display always shows all digits.

Test Plan (TICK_DIV=4, SCAN_DIV=2):
- Reset held 10 cycles then released → an=FE, dec_cat=03. Sweep index 0..7 → codes 03,03,FD,03,03,FD,03,03 with an FE,FD,…,7F.
- RUN, 60 ticks (240 cycles) → time 00:01:00. Preload 23:59:59 via SET modes, one tick → 00:00:00.
- cont held 350 cycles → exactly one mode advance (RUN→SET_H). Four soma pulses, each 5 cycles high/5 low → hours=4; time frozen across 100 cycles.
- SET_M, minutes 0, one subtracao pulse → 59. SET_H at 23, soma → 0 with minutes unchanged.
- soma and subtracao rising on the same cycle in SET_S → seconds unchanged. cont with soma on the same cycle → mode advances only.
- Four cont events from RUN → back to RUN and counting resumes. Reset asserted in SET_M → RUN, 00:00:00 next edge.

Source files
------------

// File: rtl/relogio.sv
// relogio: 24-hour HH:MM:SS clock with a set mode, driving an 8-digit multiplexed 7-segment display.
// Buttons act two edges after the synchronizer; defining RELOGIO_BLINK_EN blanks the field being set.
// No backpressure: button events are single-cycle pulses, and the display follows the scan index combinationally.
module relogio #(
  parameter int TICK_DIV = 100000000,
  parameter int SCAN_DIV = 100000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       soma,
  input  logic       subtracao,
  input  logic       cont,
  output logic [7:0] an,
  output logic [7:0] dec_cat
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = $clog2(SCAN_DIV + 1);
  localparam logic [PW-1:0] PRE_MAX  = PW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_MAX = SW'(SCAN_DIV - 1);

  typedef enum logic [1:0] {RUN, SET_H, SET_M, SET_S} mode_t;
  mode_t mode, mode_nxt;

  logic [2:0] sync1, sync2, sync3;
  logic       ev_soma, ev_sub, ev_cont;
  logic [PW-1:0] pre;
  logic       tick;
  logic [7:0] hh, mm, ss;
  logic       sel_h, sel_m, sel_s, adv, adj_inc, adj_dec;
  logic [SW-1:0] scan;
  logic [2:0] idx;
  logic [3:0] dig;
  logic       dash, blank;

  // Fields are packed BCD {tens, units}; max is the wrap value (8'h23 or 8'h59).
  function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max);
    if (v == max)             return 8'h00;
    else if (v[3:0] == 4'd9)  return {v[7:4] + 4'd1, 4'd0};
    else                      return {v[7:4], v[3:0] + 4'd1};
  endfunction

  function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max);
    if (v == 8'h00)           return max;
    else if (v[3:0] == 4'd0)  return {v[7:4] - 4'd1, 4'd9};
    else                      return {v[7:4], v[3:0] - 4'd1};
  endfunction

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
      sync3 <= '0;
    end else begin
      sync1 <= {cont, subtracao, soma};
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  assign {ev_cont, ev_sub, ev_soma} = sync2 & ~sync3;

  always_ff @(posedge clock) begin
    if (reset)               pre <= '0;
    else if (pre == PRE_MAX) pre <= '0;
    else                     pre <= pre + 1'b1;
  end

  assign tick = (pre == PRE_MAX);

  always_ff @(posedge clock) begin
    if (reset) mode <= RUN;
    else       mode <= mode_nxt;
  end

  always_comb begin
    mode_nxt = mode;
    if (ev_cont) begin
      case (mode)
        RUN:     mode_nxt = SET_H;
        SET_H:   mode_nxt = SET_M;
        SET_M:   mode_nxt = SET_S;
        default: mode_nxt = RUN;
      endcase
    end
  end

  // A mode advance takes priority over adjustment; opposing buttons cancel.
  always_comb begin
    sel_h   = (mode == SET_H);
    sel_m   = (mode == SET_M);
    sel_s   = (mode == SET_S);
    adv     = (mode == RUN) && tick;
    adj_inc = (mode != RUN) && ev_soma && !ev_sub && !ev_cont;
    adj_dec = (mode != RUN) && ev_sub && !ev_soma && !ev_cont;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      hh <= 8'h00;
      mm <= 8'h00;
      ss <= 8'h00;
    end else if (adv) begin
      ss <= bcd_inc(ss, 8'h59);
      if (ss == 8'h59) begin
        mm <= bcd_inc(mm, 8'h59);
        if (mm == 8'h59) hh <= bcd_inc(hh, 8'h23);
      end
    end else if (adj_inc) begin
      if (sel_h) hh <= bcd_inc(hh, 8'h23);
      if (sel_m) mm <= bcd_inc(mm, 8'h59);
      if (sel_s) ss <= bcd_inc(ss, 8'h59);
    end else if (adj_dec) begin
      if (sel_h) hh <= bcd_dec(hh, 8'h23);
      if (sel_m) mm <= bcd_dec(mm, 8'h59);
      if (sel_s) ss <= bcd_dec(ss, 8'h59);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      scan <= '0;
      idx  <= 3'd0;
    end else if (scan == SCAN_MAX) begin
      scan <= '0;
      idx  <= idx + 3'd1;
    end else begin
      scan <= scan + 1'b1;
    end
  end

  assign an = ~(8'd1 << idx);

  always_comb begin
    dig   = 4'd0;
    dash  = 1'b0;
    blank = 1'b0;
    case (idx)
      3'd0:    dig  = ss[3:0];
      3'd1:    dig  = ss[7:4];
      3'd2:    dash = 1'b1;
      3'd3:    dig  = mm[3:0];
      3'd4:    dig  = mm[7:4];
      3'd5:    dash = 1'b1;
      3'd6:    dig  = hh[3:0];
      default: dig  = hh[7:4];
    endcase
`ifdef RELOGIO_BLINK_EN
    if (pre >= PW'(TICK_DIV / 2))
      blank = (sel_h && (idx == 3'd6 || idx == 3'd7)) ||
              (sel_m && (idx == 3'd3 || idx == 3'd4)) ||
              (sel_s && (idx == 3'd0 || idx == 3'd1));
`endif
  end

  always_comb begin
    dec_cat = 8'hFF;
    if (!blank) begin
      if (dash) dec_cat = 8'hFD;
      else begin
        case (dig)
          4'd0:    dec_cat = 8'h03;
          4'd1:    dec_cat = 8'h9F;
          4'd2:    dec_cat = 8'h25;
          4'd3:    dec_cat = 8'h0D;
          4'd4:    dec_cat = 8'h99;
          4'd5:    dec_cat = 8'h49;
          4'd6:    dec_cat = 8'h41;
          4'd7:    dec_cat = 8'h1F;
          4'd8:    dec_cat = 8'h01;
          4'd9:    dec_cat = 8'h09;
          default: dec_cat = 8'hFF;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_relogio.sv
// Bench for relogio at TICK_DIV=4, SCAN_DIV=2; the time is read back by scanning the display while frozen in a set mode.
// Run-mode checks freeze the clock with a cont edge placed at a known prescaler phase.
module tb_relogio;
  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       soma = 1'b0;
  logic       subtracao = 1'b0;
  logic       cont = 1'b0;
  logic [7:0] an, dec_cat;
  int         n_cmp = 0;
  int         n_bad = 0;
  int         ncyc = 0;

  typedef struct {
    logic  s;
    logic  d;
    logic  c;
    int    n;
    int    h;
    int    m;
    int    sec;
    string name;
  } vec_t;

  vec_t       tbl [13];
  logic [7:0] an_tab  [8];
  logic [7:0] cat_tab [8];
  logic [63:0] v;

  relogio #(.TICK_DIV(4), .SCAN_DIV(2)) dut (
    .clock(clock), .reset(reset), .soma(soma), .subtracao(subtracao),
    .cont(cont), .an(an), .dec_cat(dec_cat)
  );

  always #5 clock = ~clock;

  // Edges since reset release; prescaler phase equals ncyc mod 4.
  always @(posedge clock) ncyc <= reset ? 0 : ncyc + 1;

  function automatic logic [7:0] seg(input int d);
    case (d)
      0: return 8'h03;
      1: return 8'h9F;
      2: return 8'h25;
      3: return 8'h0D;
      4: return 8'h99;
      5: return 8'h49;
      6: return 8'h41;
      7: return 8'h1F;
      8: return 8'h01;
      9: return 8'h09;
      10: return 8'hFD;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [63:0] disp(input int h, input int m, input int s);
    return {seg(h / 10), seg(h % 10), seg(10), seg(m / 10), seg(m % 10), seg(10), seg(s / 10), seg(s % 10)};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic read_disp(output logic [63:0] r);
    r = '1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      for (int i = 0; i < 8; i++)
        if (an == ~(8'd1 << i)) r[i*8 +: 8] = dec_cat;
    end
  endtask

  task automatic check_time(input string name, input int h, input int m, input int s);
    logic [63:0] r;
    read_disp(r);
    check(name, r, disp(h, m, s));
  endtask

  task automatic press(input logic ps, input logic pd, input logic pc, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clock);
      soma = ps; subtracao = pd; cont = pc;
      repeat (5) @(negedge clock);
      soma = 1'b0; subtracao = 1'b0; cont = 1'b0;
      repeat (4) @(negedge clock);
    end
    repeat (2) @(negedge clock);
  endtask

  // From SET_S: cont (optionally with soma) enters RUN at base+3, then a
  // second cont lands at base+4*nt+1, so exactly nt ticks are counted.
  task automatic run_ticks(input int nt, input logic with_soma);
    int base;
    @(negedge clock);
    while (ncyc % 4 != 0) @(negedge clock);
    base = ncyc;
    cont = 1'b1; soma = with_soma;
    @(negedge clock);
    cont = 1'b0; soma = 1'b0;
    while (ncyc < base + 4 * nt - 2) @(negedge clock);
    cont = 1'b1;
    @(negedge clock);
    cont = 1'b0;
    repeat (5) @(negedge clock);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required finish");
    $fatal(1);
  end

  initial begin
    an_tab  = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};
    cat_tab = '{8'h03, 8'h03, 8'hFD, 8'h03, 8'h03, 8'hFD, 8'h03, 8'h03};
    // Applied from SET_H at 04:01:00.
    tbl[0]  = '{1'b0, 1'b1, 1'b0, 5, 23,  1,  0, "h_dec_wrap_0_to_23"};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1,  0,  1,  0, "h_inc_wrap_23_to_0"};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 1, 23,  1,  0, "h_dec_back_23"};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 1, 23,  1,  0, "to_set_m"};
    tbl[4]  = '{1'b0, 1'b1, 1'b0, 1, 23,  0,  0, "m_dec_1_to_0"};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1, 23, 59,  0, "m_dec_wrap_0_to_59"};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 1, 23,  0,  0, "m_inc_wrap_no_carry"};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1, 23, 59,  0, "m_dec_back_59"};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 1, 23, 59,  0, "to_set_s"};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 1, 23, 59,  0, "s_inc_dec_same_cycle"};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 1, 23, 59, 59, "s_dec_wrap_0_to_59"};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1, 23, 59,  0, "s_inc_wrap_no_carry"};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 1, 23, 59, 59, "s_preload_59"};

    repeat (10) @(posedge clock);
    @(negedge clock);
    check("reset_an", {56'd0, an}, {56'd0, 8'hFE});
    check("reset_cat", {56'd0, dec_cat}, {56'd0, 8'h03});
    reset = 1'b0;

    for (int i = 0; i < 8; i++) begin
      if (i > 0) repeat (2) @(negedge clock);
      check($sformatf("sweep_%0d", i), {48'd0, an, dec_cat}, {48'd0, an_tab[i], cat_tab[i]});
    end

    // cont rises after edge 240: freeze lands on edge 243, after the 60th tick.
    while (ncyc < 240) @(negedge clock);
    cont = 1'b1;
    repeat (350) @(negedge clock);
    cont = 1'b0;
    repeat (5) @(negedge clock);
    check_time("run_60_ticks", 0, 1, 0);

    press(1'b1, 1'b0, 1'b0, 4);
    check_time("held_cont_one_advance_soma_x4", 4, 1, 0);
    repeat (100) @(negedge clock);
    check_time("set_mode_frozen", 4, 1, 0);

    for (int i = 0; i < 13; i++) begin
      press(tbl[i].s, tbl[i].d, tbl[i].c, tbl[i].n);
      check_time(tbl[i].name, tbl[i].h, tbl[i].m, tbl[i].sec);
    end

    run_ticks(1, 1'b1);
    check_time("cont_with_soma_then_wrap", 0, 0, 0);

    press(1'b0, 1'b0, 1'b1, 2);
    run_ticks(41, 1'b0);
    check_time("four_conts_resume_41", 0, 0, 41);

    press(1'b1, 1'b0, 1'b0, 1);
    press(1'b0, 1'b0, 1'b1, 1);
    check_time("pre_reset_set_m", 1, 0, 41);

    reset = 1'b1;
    @(negedge clock);
    check("mid_reset_an", {56'd0, an}, {56'd0, 8'hFE});
    check("mid_reset_cat", {56'd0, dec_cat}, {56'd0, 8'h03});
    reset = 1'b0;
    // Running after reset: cont after edge 8 freezes at edge 11, two ticks in.
    while (ncyc < 8) @(negedge clock);
    cont = 1'b1;
    @(negedge clock);
    cont = 1'b0;
    repeat (5) @(negedge clock);
    check_time("after_reset_runs", 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
